// File: rtl/wb_uart_lite_if.sv
// Wishbone classic slave bus bundle for wb_uart_lite.
//   master: drives stb/cyc/we/sel/adr/dat_i, receives ack/dat_o
//   slave : the UART side of the same signals
interface wb_uart_lite_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_uart_lite.sv
// Minimal Wishbone UART: TX FIFO + 8N1 transmitter, optional 8N1 receiver.
// Build option: define UART_RX_EN to include the receiver; without it
// uart_rx_i is ignored, RXDATA/STATUS[4:2] read 0 and irq_o stays 0.
// Ports:
//   clk_i, rstn_i  clock, async active-low reset
//   wbs            Wishbone classic slave (wb_uart_lite_if.slave)
//   uart_tx_o      serial out (idle high)
//   uart_rx_i      serial in
//   irq_o          level interrupt: rx_valid | rx_overrun | rx_frame_err
// Registers (adr[3:2]): 0 TXDATA(wo) 1 RXDATA 2 STATUS 3 DIV (bit time = DIV+1 clocks)
module wb_uart_lite #(
  parameter logic [15:0] DIV_RESET     = 16'd433,
  parameter int          TX_FIFO_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  wb_uart_lite_if.slave  wbs,
  output logic           uart_tx_o,
  input  logic           uart_rx_i,
  output logic           irq_o
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  // ---------------- bus decode ----------------
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic        req, wr, rd;
  logic [1:0]  adr;
  assign req = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  assign wr  = req & wbs.wbs_we_i;
  assign rd  = req & ~wbs.wbs_we_i;
  assign adr = wbs.wbs_adr_i[3:2];

  logic [15:0] div_q, div_d;
  always_comb begin
    div_d = div_q;
    if (wr && adr == 2'd3) begin
      if (wbs.wbs_sel_i[0]) div_d[7:0]  = wbs.wbs_dat_i[7:0];
      if (wbs.wbs_sel_i[1]) div_d[15:8] = wbs.wbs_dat_i[15:8];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_q [TX_FIFO_DEPTH];
  logic [7:0]  fifo_d [TX_FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic tx_full, fifo_empty, push, pop;
  assign tx_full    = (cnt_q == (AW+1)'(TX_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A full FIFO still accepts a push when the transmitter pops the same cycle.
  assign push = wr && adr == 2'd0 && wbs.wbs_sel_i[0] && (!tx_full || pop);

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wp_q] = wbs.wbs_dat_i[7:0];
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop  ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // ---------------- TX FSM ----------------
  logic [1:0]  tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d, tx_tick;
  assign tx_tick = (tx_cnt_q == '0);

  // Bit counter reloads from div_q only at bit boundaries, so a DIV write
  // never stretches or truncates the bit currently on the wire.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    if (tx_st_q != S_IDLE && !tx_tick) tx_cnt_d = tx_cnt_q - 16'd1;
    case (tx_st_q)
      S_IDLE: if (!fifo_empty) begin
        pop = 1'b1; tx_sh_d = fifo_q[rp_q]; tx_st_d = S_START; tx_cnt_d = div_q; txd_d = 1'b0;
      end
      S_START: if (tx_tick) begin
        tx_st_d = S_DATA; tx_cnt_d = div_q; tx_bit_d = '0; txd_d = tx_sh_q[0];
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_d = div_q;
        if (tx_bit_q == 3'd7) begin
          tx_st_d = S_STOP; txd_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = tx_sh_q >> 1; txd_d = tx_sh_q[1];
        end
      end
      default: if (tx_tick) begin
        if (!fifo_empty) begin
          pop = 1'b1; tx_sh_d = fifo_q[rp_q]; tx_st_d = S_START; tx_cnt_d = div_q; txd_d = 1'b0;
        end else begin
          tx_st_d = S_IDLE; txd_d = 1'b1;
        end
      end
    endcase
  end

  // ---------------- RX ----------------
  logic       rx_valid, rx_ovr, rx_fe;
  logic [7:0] rx_data;
`ifdef UART_RX_EN
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0] rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, half;
  logic [16:0] div_p1;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_fe_q, rx_fe_d;
  logic rx_tick, load, ovr_set, fe_set, rd_rx, clr_ovr, clr_fe;

  assign div_p1  = {1'b0, div_q} + 17'd1;
  assign half    = div_p1[16:1];
  assign rx_tick = (rx_cnt_q == '0);
  assign rd_rx   = rd && adr == 2'd1;
  assign clr_ovr = wr && adr == 2'd2 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[3];
  assign clr_fe  = wr && adr == 2'd2 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[4];

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    load = 1'b0; ovr_set = 1'b0; fe_set = 1'b0;
    if (rx_st_q != S_IDLE && !rx_tick) rx_cnt_d = rx_cnt_q - 16'd1;
    case (rx_st_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = S_START; rx_cnt_d = half;
      end
      // Mid-start-bit check: a line already back high was a glitch.
      S_START: if (rx_tick) begin
        if (rx_s2_q) rx_st_d = S_IDLE;
        else begin rx_st_d = S_DATA; rx_cnt_d = div_q; rx_bit_d = '0; end
      end
      S_DATA: if (rx_tick) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]}; rx_cnt_d = div_q;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      default: if (rx_tick) begin
        rx_st_d = S_IDLE;
        if (!rx_s2_q)       fe_set  = 1'b1;
        else if (rx_valid_q) ovr_set = 1'b1;
        else                load    = 1'b1;
      end
    endcase
    // Sets win over same-cycle clears.
    rx_data_d  = load ? rx_sh_q : rx_data_q;
    rx_valid_d = (rx_valid_q & ~rd_rx) | load;
    rx_ovr_d   = (rx_ovr_q & ~clr_ovr) | ovr_set;
    rx_fe_d    = (rx_fe_q & ~clr_fe) | fe_set;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_data_q <= '0;
      rx_valid_q <= 1'b0; rx_ovr_q <= 1'b0; rx_fe_q <= 1'b0;
    end else begin
      rx_s1_q <= uart_rx_i; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d; rx_ovr_q <= rx_ovr_d; rx_fe_q <= rx_fe_d;
    end
  end
  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_fe    = rx_fe_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_valid = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_fe    = 1'b0;
  assign rx_data  = '0;
`endif

  // ---------------- read mux / outputs ----------------
  logic irq_q, irq_d, tx_empty;
  assign tx_empty = fifo_empty && tx_st_q == S_IDLE;

  always_comb begin
    case (adr)
      2'd1:    rdata = {24'd0, rx_data};
      2'd2:    rdata = {27'd0, rx_fe, rx_ovr, rx_valid, tx_empty, tx_full};
      2'd3:    rdata = {16'd0, div_q};
      default: rdata = '0;
    endcase
    ack_d = req;
    dat_d = rd ? rdata : 32'd0;
    irq_d = rx_valid | rx_ovr | rx_fe;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q <= 1'b0; dat_q <= '0; irq_q <= 1'b0; div_q <= DIV_RESET;
      for (int i = 0; i < TX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; txd_q <= 1'b1;
    end else begin
      ack_q <= ack_d; dat_q <= dat_d; irq_q <= irq_d; div_q <= div_d;
      fifo_q <= fifo_d;
      wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d;
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d; txd_q <= txd_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign uart_tx_o     = txd_q;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_uart_lite.sv
// Directed bench for wb_uart_lite: bus access tasks, a serial frame monitor
// on uart_tx_o, and hand-computed expected register/frame values.
module tb_wb_uart_lite;
  logic clk_i = 1'b0;
  logic rstn_i;
  logic uart_tx_o, uart_rx_i, irq_o;

  wb_uart_lite_if bus ();

  wb_uart_lite #(.DIV_RESET(16'd433), .TX_FIFO_DEPTH(4)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .wbs       (bus.slave),
    .uart_tx_o (uart_tx_o),
    .uart_rx_i (uart_rx_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_acc(input logic we, input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rdv);
    int n;
    @(posedge clk_i); #1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = {28'd0, a}; bus.wbs_sel_i = sel; bus.wbs_dat_i = wd;
    n = 0;
    do begin @(posedge clk_i); #1; n++; end while (!bus.wbs_ack_o && n < 20);
    chk("wb_ack", {31'd0, bus.wbs_ack_o}, 32'd1);
    rdv = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] sel = 4'hF);
    logic [31:0] r;
    wb_acc(1'b1, a, wd, sel, r);
    chk("wr_dat_zero", r, 32'd0);
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_acc(1'b0, a, 32'd0, 4'hF, r);
    chk(tag, r, exp);
  endtask

  // ---- serial monitor on uart_tx_o; bt = expected clocks per bit ----
  int bt = 4;
  bit mon_en = 1'b1;
  int tx_glitch = 0;
  logic [9:0] frq[$];

  initial begin : tx_mon
    logic [9:0] f;
    logic s0;
    int bl;
    forever begin
      @(posedge clk_i); #1;
      if (mon_en && uart_tx_o === 1'b0) begin
        bl = bt;
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < bl; j++) begin
            if (i != 0 || j != 0) begin @(posedge clk_i); #1; end
            if (j == 0) begin s0 = uart_tx_o; f[i] = s0; end
            else if (uart_tx_o !== s0) tx_glitch++;
          end
        end
        if (mon_en) frq.push_back(f);
      end
    end
  end

  task automatic wait_frames(input int n);
    int k = 0;
    while (frq.size() < n && k < 1500) begin @(posedge clk_i); #1; k++; end
    chk("frame_cnt", frq.size(), n);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] b);
    logic [9:0] f;
    f = (frq.size() != 0) ? frq.pop_front() : 10'h3FF;
    chk(tag, {22'd0, f}, {22'd0, 1'b1, b, 1'b0});
  endtask

  // Drive one 8N1 frame on uart_rx_i at 8 clocks per bit (DIV=7).
  task automatic rx_send(input logic [7:0] b, input logic stop_b);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = f[i];
      repeat (8) @(posedge clk_i);
      #1;
    end
    uart_rx_i = 1'b1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int c0, lows, k;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    uart_rx_i = 1'b1;
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    rstn_i = 1'b1;

    rdchk("rst_status", 4'h8, 32'h2);
    rdchk("rst_div", 4'hC, 32'd433);
    rdchk("rst_rxdata", 4'h4, 32'h0);
    rdchk("txdata_rd0", 4'h0, 32'h0);

    // DIV byte lanes: only byte 0 written
    wr(4'hC, 32'h0000_1234, 4'b0001);
    rdchk("div_sel0", 4'hC, 32'h0134);

    // Single frame 0x55 at DIV=3
    bt = 4;
    wr(4'hC, 32'hFFFF_0003);
    rdchk("div_3", 4'hC, 32'h3);
    wr(4'h0, 32'h55);
    wait_frames(1);
    chk_frame("tx_55", 8'h55);
    chk("tx_glitch_55", tx_glitch, 0);
    rdchk("tx_empty_after", 4'h8, 32'h2);

    // FIFO fill: 0x01 in flight, 0x02..0x05 fill depth 4, 0x06 dropped
    for (int i = 1; i <= 5; i++) wr(4'h0, i);
    rdchk("tx_full", 4'h8, 32'h1);
    wr(4'h0, 32'h06);
    wait_frames(5);
    for (int i = 1; i <= 5; i++) chk_frame("tx_fifo_order", 8'(i));
    repeat (80) @(posedge clk_i);
    #1;
    chk("tx_6th_dropped", frq.size(), 0);
    chk("tx_glitch_fifo", tx_glitch, 0);
    rdchk("tx_empty_fifo", 4'h8, 32'h2);

    // DIV=0: one clock per bit
    wr(4'hC, 32'h0);
    bt = 1;
    wr(4'h0, 32'h3C);
    wait_frames(1);
    chk_frame("tx_div0", 8'h3C);
    chk("tx_glitch_div0", tx_glitch, 0);

`ifdef UART_RX_EN
    wr(4'hC, 32'h7);
    rx_send(8'hA3, 1'b1);
    repeat (6) @(posedge clk_i);
    #1;
    rdchk("rx_valid", 4'h8, 32'h6);
    chk("rx_irq", {31'd0, irq_o}, 32'd1);
    rdchk("rx_data_a3", 4'h4, 32'hA3);
    rdchk("rx_valid_clr", 4'h8, 32'h2);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rx_irq_clr", {31'd0, irq_o}, 32'd0);

    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (6) @(posedge clk_i);
    rdchk("rx_ovr_status", 4'h8, 32'hE);
    rdchk("rx_ovr_data", 4'h4, 32'h11);
    rdchk("rx_ovr_after_rd", 4'h8, 32'hA);
    wr(4'h8, 32'h08);
    rdchk("rx_ovr_clr", 4'h8, 32'h2);

    uart_rx_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    uart_rx_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    rdchk("rx_glitch", 4'h8, 32'h2);
    chk("rx_glitch_irq", {31'd0, irq_o}, 32'd0);

    rx_send(8'h5A, 1'b0);
    repeat (10) @(posedge clk_i);
    #1;
    rdchk("rx_frame_err", 4'h8, 32'h12);
    chk("rx_fe_irq", {31'd0, irq_o}, 32'd1);
    wr(4'h8, 32'h10);
    rdchk("rx_fe_clr", 4'h8, 32'h2);
`else
    wr(4'hC, 32'h7);
    rx_send(8'hA3, 1'b1);
    repeat (6) @(posedge clk_i);
    #1;
    rdchk("norx_status", 4'h8, 32'h2);
    rdchk("norx_rxdata", 4'h4, 32'h0);
    chk("norx_irq", {31'd0, irq_o}, 32'd0);
`endif

    // Reset during data bit 3 of an all-zero byte with more bytes queued
    mon_en = 1'b0;
    bt = 4;
    wr(4'hC, 32'h3);
    wr(4'h0, 32'h00);
    k = 0;
    while (uart_tx_o !== 1'b0 && k < 20) begin @(posedge clk_i); #1; k++; end
    chk("rst_frame_start", {31'd0, uart_tx_o}, 32'd0);
    c0 = cyc;
    wr(4'h0, 32'hAA);
    wr(4'h0, 32'hBB);
    k = 0;
    while (cyc < c0 + 17 && k < 40) begin @(posedge clk_i); #1; k++; end
    chk("tx_bit3_low", {31'd0, uart_tx_o}, 32'd0);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("rst_mid_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    #2;
    rstn_i = 1'b1;
    rdchk("rst_mid_status", 4'h8, 32'h2);
    rdchk("rst_mid_div", 4'hC, 32'd433);
    rdchk("rst_mid_rxdata", 4'h4, 32'h0);
    lows = 0;
    repeat (100) begin @(posedge clk_i); #1; if (uart_tx_o !== 1'b1) lows++; end
    chk("rst_no_tx", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
